// File: rtl/paralelo_serial_pkg.sv
// Shared constants and state encoding for the parallel-to-serial transmitter.
package paralelo_serial_pkg;

  localparam int unsigned SymbolWidth = 8;
  localparam logic [SymbolWidth-1:0] ComSymbolDefault = 8'hBC;

  typedef enum logic {
    StTrain  = 1'b0,
    StActive = 1'b1
  } state_e;

endpackage

// File: rtl/paralelo_serial_piso8.sv
// 8-bit parallel-in/serial-out shift register, MSB shifted out first.
module paralelo_serial_piso8
  import paralelo_serial_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [SymbolWidth-1:0] data_i,
  output logic                   serial_o
);

  logic [SymbolWidth-1:0] shift_q, shift_d;

  always_comb begin
    shift_d = load_i ? data_i : {shift_q[SymbolWidth-2:0], 1'b0};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign serial_o = shift_q[SymbolWidth-1];

endmodule

// File: rtl/paralelo_serial.sv
// Serialises the mux-chain byte stream MSB first, preceded by a COM training burst after reset.
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter logic [SymbolWidth-1:0] COM_SYMBOL  = ComSymbolDefault,
  parameter int unsigned            TRAIN_COUNT = 4
) (
  input  logic                   clk_32f,
  input  logic                   reset,
  input  logic [SymbolWidth-1:0] data_000,
  input  logic                   valid_000,
  output logic                   data_out,
  output logic                   symbol_start,
  output logic                   link_active
);

  localparam logic [3:0] TrainCnt = 4'(TRAIN_COUNT);

  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [3:0]             train_cnt_q, train_cnt_d;
  state_e                 state_q, state_d;
  logic                   load;
  logic [SymbolWidth-1:0] next_sym;
  logic [SymbolWidth-1:0] input_sym;

  assign load      = (bit_cnt_q == 3'd7);
  assign bit_cnt_d = bit_cnt_q + 3'd1;
  assign input_sym = valid_000 ? data_000 : COM_SYMBOL;

  // Once TRAIN_COUNT COMs are out, the next load edge samples inputs and raises link_active.
  always_comb begin
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    next_sym    = COM_SYMBOL;
    if (load) begin
      unique case (state_q)
        StTrain: begin
          if (train_cnt_q == TrainCnt) begin
            next_sym = input_sym;
            state_d  = StActive;
          end else begin
            train_cnt_d = train_cnt_q + 4'd1;
          end
        end
        StActive: next_sym = input_sym;
        default:  state_d = StTrain;
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      bit_cnt_q   <= 3'd7;
      train_cnt_q <= 4'd0;
      state_q     <= StTrain;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      train_cnt_q <= train_cnt_d;
      state_q     <= state_d;
    end
  end

  paralelo_serial_piso8 u_piso8 (
    .clk_i    (clk_32f),
    .rst_ni   (reset),
    .load_i   (load),
    .data_i   (next_sym),
    .serial_o (data_out)
  );

  // bit_cnt sits at 7 during reset, so this is only reachable after an edge.
  assign symbol_start = (bit_cnt_q == 3'd0);
  assign link_active  = (state_q == StActive);

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed scoreboard bench: default build plus a TRAIN_COUNT=1 build sharing stimulus.
module tb_paralelo_serial;

  localparam logic [7:0] Com = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_000 = 8'h00;
  logic       valid_000 = 1'b0;
  logic       data_out, symbol_start, link_active;
  logic       data_out1, symbol_start1, link_active1;

  int checks = 0;
  int failures = 0;

  // Each entry: {data_out, symbol_start, link_active}
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 clk_32f = ~clk_32f;

  paralelo_serial dut (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .data_000     (data_000),
    .valid_000    (valid_000),
    .data_out     (data_out),
    .symbol_start (symbol_start),
    .link_active  (link_active)
  );

  paralelo_serial #(.TRAIN_COUNT(1)) dut1 (
    .clk_32f      (clk_32f),
    .reset        (reset),
    .data_000     (data_000),
    .valid_000    (valid_000),
    .data_out     (data_out1),
    .symbol_start (symbol_start1),
    .link_active  (link_active1)
  );

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed={d,ss,la}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one symbol slot starting just before its load edge; expectations are queued
  // up front and popped as each bit appears.
  task automatic sym(input string tag, input logic v, input logic [7:0] d,
                     input logic mid_en, input logic [7:0] mid_d,
                     input logic [7:0] e0, input logic a0,
                     input logic c1, input logic [7:0] e1, input logic a1);
    logic [2:0] exp;
    valid_000 = v;
    data_000  = d;
    for (int i = 0; i < 8; i++) begin
      q0.push_back({e0[7-i], (i == 0), a0});
      if (c1) q1.push_back({e1[7-i], (i == 0), a1});
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_32f);
      #1;
      if (mid_en && i == 3) data_000 = mid_d;
      exp = q0.pop_front();
      chk($sformatf("%s bit%0d", tag, i), {data_out, symbol_start, link_active}, exp);
      if (q1.size() != 0) begin
        exp = q1.pop_front();
        chk($sformatf("%s tc1 bit%0d", tag, i), {data_out1, symbol_start1, link_active1}, exp);
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    valid_000 = 1'b1;
    data_000  = 8'hFF;
    repeat (3) @(posedge clk_32f);
    #1;
    chk("reset dut", {data_out, symbol_start, link_active}, 3'b000);
    chk("reset tc1", {data_out1, symbol_start1, link_active1}, 3'b000);
    @(negedge clk_32f);
    reset = 1'b1;

    // Training burst then 8'hFF; TRAIN_COUNT=1 build switches to data on symbol 2
    sym("train0", 1'b1, 8'hFF, 1'b0, 8'h00, Com, 1'b0, 1'b1, Com, 1'b0);
    sym("train1", 1'b1, 8'hFF, 1'b0, 8'h00, Com, 1'b0, 1'b1, 8'hFF, 1'b1);
    sym("train2", 1'b1, 8'hFF, 1'b0, 8'h00, Com, 1'b0, 1'b0, 8'h00, 1'b0);
    sym("train3", 1'b1, 8'hFF, 1'b0, 8'h00, Com, 1'b0, 1'b0, 8'h00, 1'b0);
    sym("first_ff", 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);
    sym("second_ff", 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0);

    sym("a5", 1'b1, 8'hA5, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0);
    sym("3c", 1'b1, 8'h3C, 1'b0, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0);
    sym("00", 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
    sym("invalid55", 1'b0, 8'h55, 1'b0, 8'h00, Com, 1'b1, 1'b0, 8'h00, 1'b0);
    sym("valid_com", 1'b1, Com, 1'b0, 8'h00, Com, 1'b1, 1'b0, 8'h00, 1'b0);
    sym("toggle12", 1'b1, 8'h12, 1'b1, 8'hEE, 8'h12, 1'b1, 1'b0, 8'h00, 1'b0);

    // Reset while bit_cnt==3 of a data symbol
    valid_000 = 1'b1;
    data_000  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_32f);
      #1;
    end
    chk("pre_reset msb3", {data_out, symbol_start, link_active}, 3'b001);
    reset = 1'b0;
    #1;
    chk("mid_reset dut", {data_out, symbol_start, link_active}, 3'b000);
    chk("mid_reset tc1", {data_out1, symbol_start1, link_active1}, 3'b000);
    repeat (2) @(posedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;

    sym("retrain0", 1'b1, 8'hC3, 1'b0, 8'h00, Com, 1'b0, 1'b1, Com, 1'b0);
    sym("retrain1", 1'b1, 8'hC3, 1'b0, 8'h00, Com, 1'b0, 1'b1, 8'hC3, 1'b1);
    sym("retrain2", 1'b1, 8'hC3, 1'b0, 8'h00, Com, 1'b0, 1'b0, 8'h00, 1'b0);
    sym("retrain3", 1'b1, 8'hC3, 1'b0, 8'h00, Com, 1'b0, 1'b0, 8'h00, 1'b0);
    sym("after_retrain", 1'b1, 8'hC3, 1'b0, 8'h00, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
